// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 message-schedule block.
// Sigma shift amounts are fixed by FIPS 180-4.
package sha256_pkg;

    localparam int WORD_W = 32;
    localparam int ROUNDS = 64;

    localparam int S0_R1 = 7;
    localparam int S0_R2 = 18;
    localparam int S0_SH = 3;
    localparam int S1_R1 = 17;
    localparam int S1_R2 = 19;
    localparam int S1_SH = 10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_EMIT = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/sha256_small_sigma.sv
// SHA-256 small sigma: SEL=0 gives sigma0 (ROTR7^ROTR18^SHR3),
// SEL=1 gives sigma1 (ROTR17^ROTR19^SHR10). Pure wiring plus XOR.
module sha256_small_sigma
    import sha256_pkg::*;
#(
    parameter int SEL = 0
) (
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    localparam int R1 = (SEL == 0) ? S0_R1 : S1_R1;
    localparam int R2 = (SEL == 0) ? S0_R2 : S1_R2;
    localparam int SH = (SEL == 0) ? S0_SH : S1_SH;

    logic [WORD_W-1:0] rot1;
    logic [WORD_W-1:0] rot2;
    logic [WORD_W-1:0] shr;

    assign rot1 = {x[R1-1:0], x[WORD_W-1:R1]};
    assign rot2 = {x[R2-1:0], x[WORD_W-1:R2]};
    assign shr  = x >> SH;
    assign y    = rot1 ^ rot2 ^ shr;

endmodule

// File: rtl/sha256_msg_scheduler.sv
// Loads W0..W15 serially, then streams W0..W63 from a 16-word sliding window,
// generating W16..W63 on the fly as each word is accepted.
module sha256_msg_scheduler
    import sha256_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [5:0]        out_round,
    output logic              busy,
    output logic              done,
    output state_t            dbg_state
);

    // Handshakes: a word moves on a rising edge where valid and ready are both
    // high; valid never depends on ready, and held data stays stable meanwhile.

    state_t            state;
    logic [3:0]        load_cnt;
    logic [5:0]        round;
    logic [WORD_W-1:0] win [16];
    logic [WORD_W-1:0] s0_out;
    logic [WORD_W-1:0] s1_out;
    logic [WORD_W-1:0] w_next;
    logic              in_fire;
    logic              out_fire;

    sha256_small_sigma #(.SEL(0)) u_sigma0 (.x(win[1]),  .y(s0_out));
    sha256_small_sigma #(.SEL(1)) u_sigma1 (.x(win[14]), .y(s1_out));

    // win[0]=W[t-16], win[1]=W[t-15], win[9]=W[t-7], win[14]=W[t-2]
    assign w_next = s1_out + win[9] + s0_out + win[0];

    assign in_ready  = (state == ST_LOAD);
    assign out_valid = (state == ST_EMIT);
    assign out_word  = out_valid ? win[0] : '0;
    assign out_round = out_valid ? round : '0;
    assign busy      = (state == ST_LOAD) || (state == ST_EMIT);
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            load_cnt <= '0;
            round    <= '0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        load_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (in_fire) begin
                        win[load_cnt] <= in_word;
                        load_cnt      <= load_cnt + 4'd1;
                        if (load_cnt == 4'd15) begin
                            state <= ST_EMIT;
                            round <= '0;
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_fire) begin
                        for (int i = 0; i < 15; i++) begin
                            win[i] <= win[i+1];
                        end
                        win[15] <= w_next;
                        round   <= round + 6'd1;
                        if (round == 6'(ROUNDS - 1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// Bench for sha256_msg_scheduler: drives message blocks and compares the
// emitted schedule against a FIPS-style W[t] recurrence model.
module tb_sha256_msg_scheduler;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [5:0]  out_round;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] msg [16];
    logic [31:0] exp_q [$];
    logic [31:0] obs_w [$];
    logic [5:0]  obs_r [$];
    logic [31:0] ref_abc [$];

    sha256_msg_scheduler dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_round(out_round), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_exp();
        logic [31:0] w [64];
        for (int t = 0; t < 16; t++) w[t] = msg[t];
        for (int t = 16; t < 64; t++)
            w[t] = ref_s1(w[t-2]) + w[t-7] + ref_s0(w[t-15]) + w[t-16];
        exp_q.delete();
        for (int t = 0; t < 64; t++) exp_q.push_back(w[t]);
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) msg[i] = $urandom;
    endtask

    // ---------------- drivers ----------------
    // Pulses start, then offers msg[0..15]; optional gap after word gap_after
    // and an extra start pulse alongside word start_at.
    task automatic load_block(input int gap_after, input int gap_len, input int start_at,
                              output int rdy_low, output int early_valid);
        rdy_low = 0;
        early_valid = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_word  = msg[i];
            start    = (i == start_at);
            if (!in_ready) rdy_low++;
            if (out_valid) early_valid++;
            @(negedge clk);
            start = 1'b0;
            if (i == gap_after) begin
                in_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    in_word = $urandom;
                    if (!in_ready) rdy_low++;
                    if (out_valid) early_valid++;
                    @(negedge clk);
                end
            end
        end
        in_valid = 1'b0;
        in_word  = '0;
    endtask

    // Accepts schedule words into obs_w/obs_r. mode 0: ready always, 1: toggle,
    // 2: random. Returns early (ready low) when stop_round is presented.
    task automatic drain(input int mode, input int stall_round, input int start_round,
                         input int stop_round, output int stab_bad, output int n_done,
                         output int busy_at_done, output int timed_out);
        logic [31:0] pw;
        logic [5:0]  pr;
        logic        pstall;
        logic        r;
        int          stall_left;
        int          after;
        obs_w.delete();
        obs_r.delete();
        stab_bad = 0; n_done = 0; busy_at_done = 0; timed_out = 1;
        pstall = 1'b0; stall_left = 10; after = -1; pw = '0; pr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (done) begin
                n_done++;
                if (busy || out_valid) busy_at_done++;
            end
            if (out_valid && pstall && (out_word !== pw || out_round !== pr)) stab_bad++;
            if (stop_round >= 0 && out_valid && int'(out_round) == stop_round) begin
                out_ready = 1'b0;
                timed_out = 0;
                return;
            end
            if (after >= 0) begin
                after++;
                if (after > 3) begin
                    timed_out = 0;
                    break;
                end
            end else if (n_done > 0) begin
                after = 0;
            end
            case (mode)
                0: r = 1'b1;
                1: r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            if (stall_round >= 0 && out_valid && int'(out_round) == stall_round && stall_left > 0) begin
                r = 1'b0;
                stall_left--;
            end
            out_ready = r;
            start = (start_round >= 0 && out_valid && int'(out_round) == start_round);
            if (out_valid && r) begin
                obs_w.push_back(out_word);
                obs_r.push_back(out_round);
            end
            pstall = out_valid && !r;
            pw = out_word;
            pr = out_round;
            @(negedge clk);
        end
        out_ready = 1'b0;
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({in_ready, out_valid, out_word, out_round, busy, done, dbg_state} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got rdy=%b v=%b w=%h r=%0d busy=%b done=%b st=%0d want all 0",
                     in_ready, out_valid, out_word, out_round, busy, done, dbg_state);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset got busy=%b rdy=%b want 0 0", busy, in_ready);
        end
    endtask

    task automatic test_abc();
        int rl, ev, sb, nd, bd, to;
        set_abc();
        build_exp();
        load_block(-1, 0, -1, rl, ev);
        n_vec++;
        if (out_valid !== 1'b1 || out_round !== 6'd0 || out_word !== 32'h61626380) begin
            n_err++;
            $display("FAIL abc_first_latency got v=%b r=%0d w=%h want 1 0 61626380", out_valid, out_round, out_word);
        end
        drain(0, -1, -1, -1, sb, nd, bd, to);
        n_vec++;
        if (obs_w.size() != 64 || to != 0) begin
            n_err++;
            $display("FAIL abc_count got %0d timeout=%0d want 64 0", obs_w.size(), to);
        end
        for (int i = 0; i < obs_w.size() && i < 64; i++) begin
            n_vec++;
            if (obs_w[i] !== exp_q[i] || obs_r[i] !== 6'(i)) begin
                n_err++;
                $display("FAIL abc_word[%0d] got %h/%0d want %h/%0d", i, obs_w[i], obs_r[i], exp_q[i], i);
            end
        end
        if (obs_w.size() == 64) begin
            n_vec++;
            if (obs_w[16] !== 32'h61626380 || obs_w[17] !== 32'h000F0000 || obs_w[63] !== 32'h12B1EDEB) begin
                n_err++;
                $display("FAIL abc_known got W16=%h W17=%h W63=%h want 61626380 000f0000 12b1edeb",
                         obs_w[16], obs_w[17], obs_w[63]);
            end
        end
        n_vec++;
        if (nd != 1 || bd != 0) begin
            n_err++;
            $display("FAIL abc_done got pulses=%0d busy_overlap=%0d want 1 0", nd, bd);
        end
        ref_abc = obs_w;
    endtask

    task automatic test_back_pressure();
        int rl, ev, sb, nd, bd, to;
        set_abc();
        load_block(-1, 0, -1, rl, ev);
        drain(1, 20, -1, -1, sb, nd, bd, to);
        n_vec++;
        if (sb != 0) begin
            n_err++;
            $display("FAIL bp_stable got %0d unstable stall cycles want 0", sb);
        end
        n_vec++;
        if (obs_w.size() != ref_abc.size() || to != 0 || nd != 1) begin
            n_err++;
            $display("FAIL bp_count got %0d words done=%0d want %0d words done=1", obs_w.size(), nd, ref_abc.size());
        end
        for (int i = 0; i < obs_w.size() && i < ref_abc.size(); i++) begin
            n_vec++;
            if (obs_w[i] !== ref_abc[i] || obs_r[i] !== 6'(i)) begin
                n_err++;
                $display("FAIL bp_word[%0d] got %h/%0d want %h/%0d", i, obs_w[i], obs_r[i], ref_abc[i], i);
            end
        end
    endtask

    task automatic test_input_gaps();
        int rl, ev, sb, nd, bd, to;
        set_random();
        build_exp();
        load_block(7, 5, -1, rl, ev);
        n_vec++;
        if (rl != 0 || ev != 0) begin
            n_err++;
            $display("FAIL gap_load got ready_low=%0d early_valid=%0d want 0 0", rl, ev);
        end
        drain(0, -1, -1, -1, sb, nd, bd, to);
        n_vec++;
        if (obs_w.size() != 64 || nd != 1) begin
            n_err++;
            $display("FAIL gap_count got %0d done=%0d want 64 1", obs_w.size(), nd);
        end
        for (int i = 0; i < obs_w.size() && i < 64; i++) begin
            n_vec++;
            if (obs_w[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL gap_word[%0d] got %h want %h", i, obs_w[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int rl, ev, sb, nd, bd, to;
        set_random();
        build_exp();
        load_block(-1, 0, 3, rl, ev);
        drain(0, -1, 30, -1, sb, nd, bd, to);
        n_vec++;
        if (obs_w.size() != 64 || nd != 1) begin
            n_err++;
            $display("FAIL start_ign_count got %0d done=%0d want 64 1", obs_w.size(), nd);
        end
        for (int i = 0; i < obs_w.size() && i < 64; i++) begin
            n_vec++;
            if (obs_w[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL start_ign_word[%0d] got %h want %h", i, obs_w[i], exp_q[i]);
            end
        end
        n_vec++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL start_ign_idle got busy=%b v=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_reset_mid_block();
        int rl, ev, sb, nd, bd, to;
        set_abc();
        load_block(-1, 0, -1, rl, ev);
        drain(0, -1, -1, 40, sb, nd, bd, to);
        n_vec++;
        if (obs_w.size() != 40 || to != 0) begin
            n_err++;
            $display("FAIL rst_mid_reach got %0d words timeout=%0d want 40 0", obs_w.size(), to);
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({in_ready, out_valid, out_word, out_round, busy, done} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outputs got rdy=%b v=%b w=%h r=%0d busy=%b done=%b want all 0",
                     in_ready, out_valid, out_word, out_round, busy, done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        load_block(-1, 0, -1, rl, ev);
        drain(0, -1, -1, -1, sb, nd, bd, to);
        n_vec++;
        if (obs_w.size() != 64 || nd != 1) begin
            n_err++;
            $display("FAIL rst_rerun_count got %0d done=%0d want 64 1", obs_w.size(), nd);
        end
        for (int i = 0; i < obs_w.size() && i < ref_abc.size(); i++) begin
            n_vec++;
            if (obs_w[i] !== ref_abc[i]) begin
                n_err++;
                $display("FAIL rst_rerun_word[%0d] got %h want %h", i, obs_w[i], ref_abc[i]);
            end
        end
    endtask

    task automatic test_all_ones();
        int rl, ev, sb, nd, bd, to;
        logic [63:0] wide;
        logic [31:0] w16;
        for (int i = 0; i < 16; i++) msg[i] = 32'hFFFFFFFF;
        build_exp();
        wide = 64'h0FFFFFFFF + 64'h0FFFFFFFF + 64'(ref_s0(32'hFFFFFFFF)) + 64'(ref_s1(32'hFFFFFFFF));
        w16 = wide[31:0];
        load_block(-1, 0, -1, rl, ev);
        drain(2, -1, -1, -1, sb, nd, bd, to);
        n_vec++;
        if (obs_w.size() != 64 || nd != 1) begin
            n_err++;
            $display("FAIL ones_count got %0d done=%0d want 64 1", obs_w.size(), nd);
        end
        if (obs_w.size() > 16) begin
            n_vec++;
            if (obs_w[16] !== w16 || obs_w[16] !== 32'h203FFFFC) begin
                n_err++;
                $display("FAIL ones_w16 got %h want %h", obs_w[16], w16);
            end
        end
        for (int i = 0; i < obs_w.size() && i < 64; i++) begin
            n_vec++;
            if (obs_w[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL ones_word[%0d] got %h want %h", i, obs_w[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random_blocks();
        int rl, ev, sb, nd, bd, to;
        for (int b = 0; b < 4; b++) begin
            set_random();
            build_exp();
            load_block($urandom_range(0, 14), $urandom_range(0, 4), -1, rl, ev);
            drain(2, -1, -1, -1, sb, nd, bd, to);
            n_vec++;
            if (obs_w.size() != 64 || nd != 1 || sb != 0) begin
                n_err++;
                $display("FAIL rand%0d_count got %0d done=%0d unstable=%0d want 64 1 0", b, obs_w.size(), nd, sb);
            end
            for (int i = 0; i < obs_w.size() && i < 64; i++) begin
                n_vec++;
                if (obs_w[i] !== exp_q[i] || obs_r[i] !== 6'(i)) begin
                    n_err++;
                    $display("FAIL rand%0d_word[%0d] got %h/%0d want %h/%0d", b, i, obs_w[i], obs_r[i], exp_q[i], i);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_abc();
        test_back_pressure();
        test_input_gaps();
        test_start_ignored();
        test_reset_mid_block();
        test_all_ones();
        test_random_blocks();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
